// File: rtl/keypad_display_driver_pkg.sv
// Shared definitions for the keypad receive and display path:
// debounce states, segment patterns and code field positions.
package keypad_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } deb_state_e;

  localparam int CODE_VALID   = 4;
  localparam int CODE_BCD_MSB = 3;
  localparam int CODE_BCD_LSB = 0;

  // gfedcba, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to active-low gfedcba decoder.
// Non-decimal codes show a dash.
module bcd_to_7seg
  import keypad_display_driver_pkg::*;
(
  input  logic [3:0] bcd_in,
  output logic [6:0] seg_out
);

  always_comb begin
    seg_out = SEG_DASH;
    case (bcd_in)
      4'd0:    seg_out = SEG_0;
      4'd1:    seg_out = SEG_1;
      4'd2:    seg_out = SEG_2;
      4'd3:    seg_out = SEG_3;
      4'd4:    seg_out = SEG_4;
      4'd5:    seg_out = SEG_5;
      4'd6:    seg_out = SEG_6;
      4'd7:    seg_out = SEG_7;
      4'd8:    seg_out = SEG_8;
      4'd9:    seg_out = SEG_9;
      default: seg_out = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/keypad_display_driver.sv
// Debounces encoder codes into key events, buffers digits and
// drives a multiplexed active-low seven-segment display.
module keypad_display_driver
  import keypad_display_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 16
) (
  input  logic                            Clk_in,
  input  logic                            Rst_n_in,
  input  logic [4:0]                      Code_in,
  input  logic                            Clear_in,
  output logic [6:0]                      Seg_out,
  output logic [NUM_DIGITS-1:0]           Anode_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0] Count_out,
  output logic                            Full_out,
  output logic                            Key_strobe_out
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV);

  logic [4:0] sync1_q;
  logic [4:0] code_s_q;

  deb_state_e state_q, state_d;
  logic [4:0] cap_q, cap_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic accept;
  logic strobe_q;

  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [CW-1:0] count_q, count_d;
  logic full;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d, seg_dec;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  assign full = (count_q == CW'(NUM_DIGITS));

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    deb_cnt_d = deb_cnt_q;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (code_s_q[CODE_VALID]) begin
          cap_d     = code_s_q;
          deb_cnt_d = DW'(1);
          state_d   = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (!code_s_q[CODE_VALID]) begin
          state_d = ST_IDLE;
        end else if (code_s_q != cap_q) begin
          cap_d     = code_s_q;
          deb_cnt_d = DW'(1);
        end else if (deb_cnt_q == DW'(DEB_CYCLES)) begin
          accept  = 1'b1;
          state_d = ST_HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      ST_HELD: begin
        if (!code_s_q[CODE_VALID]) begin
          deb_cnt_d = DW'(1);
          state_d   = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (code_s_q[CODE_VALID]) begin
          state_d = ST_HELD;
        end else if (deb_cnt_q == DW'(DEB_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear wins over a same-cycle accept; the strobe is unaffected.
  always_comb begin
    digit_d = digit_q;
    count_d = count_q;
    if (Clear_in) begin
      digit_d = '0;
      count_d = '0;
    end else if (accept && !full) begin
      digit_d = {digit_q[NUM_DIGITS-2:0],
                 cap_q[CODE_BCD_MSB:CODE_BCD_LSB]};
      count_d = count_q + CW'(1);
    end
  end

  bcd_to_7seg u_dec (
    .bcd_in  (digit_q[idx_q]),
    .seg_out (seg_dec)
  );

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) idx_d = '0;
      else idx_d = idx_q + IW'(1);
    end
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d   = (CW'(idx_q) < count_q) ? seg_dec : SEG_BLANK;
  end

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      sync1_q    <= '0;
      code_s_q   <= '0;
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      deb_cnt_q  <= '0;
      strobe_q   <= 1'b0;
      digit_q    <= '0;
      count_q    <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      anode_q    <= '1;
    end else begin
      sync1_q    <= Code_in;
      code_s_q   <= sync1_q;
      state_q    <= state_d;
      cap_q      <= cap_d;
      deb_cnt_q  <= deb_cnt_d;
      strobe_q   <= accept;
      digit_q    <= digit_d;
      count_q    <= count_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      anode_q    <= anode_d;
    end
  end

  assign Seg_out        = seg_q;
  assign Anode_out      = anode_q;
  assign Count_out      = count_q;
  assign Full_out       = full;
  assign Key_strobe_out = strobe_q;

endmodule

// File: tb/tb_keypad_display_driver.sv
// Directed bench for keypad_display_driver with a short scan
// period so whole refresh frames are cheap to observe.
module tb_keypad_display_driver;

  localparam int ND  = 4;
  localparam int SD  = 4;
  localparam int DEB = 16;

  logic       Clk_in = 1'b0;
  logic       Rst_n_in = 1'b0;
  logic [4:0] Code_in = '0;
  logic       Clear_in = 1'b0;
  logic [6:0] Seg_out;
  logic [3:0] Anode_out;
  logic [2:0] Count_out;
  logic       Full_out;
  logic       Key_strobe_out;

  int n_checks = 0;
  int n_fail = 0;
  logic [6:0] seg_seen [4];

  always #5 Clk_in = ~Clk_in;

  keypad_display_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEB_CYCLES (DEB)
  ) dut (
    .Clk_in         (Clk_in),
    .Rst_n_in       (Rst_n_in),
    .Code_in        (Code_in),
    .Clear_in       (Clear_in),
    .Seg_out        (Seg_out),
    .Anode_out      (Anode_out),
    .Count_out      (Count_out),
    .Full_out       (Full_out),
    .Key_strobe_out (Key_strobe_out)
  );

  task automatic press(input logic [4:0] code, input int hold,
                       input int rel, output int pulses,
                       output int first);
    pulses = 0;
    first  = -1;
    Code_in = code;
    for (int i = 0; i < hold + rel; i++) begin
      if (i == hold) Code_in = '0;
      @(posedge Clk_in); #1;
      if (Key_strobe_out) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic capture();
    for (int p = 0; p < 4; p++) seg_seen[p] = 'x;
    for (int i = 0; i < 4 * SD; i++) begin
      @(posedge Clk_in); #1;
      for (int p = 0; p < 4; p++)
        if (Anode_out == ~(4'b0001 << p)) seg_seen[p] = Seg_out;
    end
  endtask

  task automatic do_clear();
    Clear_in = 1'b1;
    @(posedge Clk_in); #1;
    Clear_in = 1'b0;
    n_checks++;
    if (Count_out !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_count: got %0d expected 0", Count_out);
    end
  endtask

  task automatic check_frame(input string nm,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_s [4];
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    capture();
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (seg_seen[p] !== exp_s[p]) begin
        n_fail++;
        $display("FAIL %s_pos%0d: got %b expected %b",
                 nm, p, seg_seen[p], exp_s[p]);
      end
    end
  endtask

  task automatic test_reset();
    Rst_n_in = 1'b0;
    Code_in = '0;
    #12;
    n_checks++;
    if ({Seg_out, Anode_out} !== {7'h7f, 4'hf}) begin
      n_fail++;
      $display("FAIL reset_disp: got %b %b expected 1111111 1111",
               Seg_out, Anode_out);
    end
    n_checks++;
    if ({Count_out, Full_out, Key_strobe_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %0d %b %b expected 0 0 0",
               Count_out, Full_out, Key_strobe_out);
    end
    @(negedge Clk_in);
    Rst_n_in = 1'b1;
    @(posedge Clk_in); #1;
    n_checks++;
    if (Anode_out !== 4'b1110 || Seg_out !== 7'h7f) begin
      n_fail++;
      $display("FAIL first_refresh: got %b %b expected 1110 1111111",
               Anode_out, Seg_out);
    end
  endtask

  task automatic test_clean_press();
    int pulses, first;
    press(5'b10111, 40, 40, pulses, first);
    n_checks++;
    if (pulses !== 1 || first !== 2 + DEB) begin
      n_fail++;
      $display("FAIL clean_strobe: got %0d pulses at %0d expected 1 at %0d",
               pulses, first, 2 + DEB);
    end
    n_checks++;
    if (Count_out !== 3'd1 || Full_out !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_count: got %0d full %b expected 1 full 0",
               Count_out, Full_out);
    end
    check_frame("clean", 7'b1111000, 7'h7f, 7'h7f, 7'h7f);
  endtask

  task automatic test_bounce();
    int bp, pulses, first;
    bp = 0;
    for (int i = 0; i < 60; i++) begin
      Code_in = ((i / 5) % 2 == 0) ? 5'b10011 : 5'b00000;
      @(posedge Clk_in); #1;
      if (Key_strobe_out) bp++;
    end
    n_checks++;
    if (bp !== 0) begin
      n_fail++;
      $display("FAIL bounce_quiet: got %0d pulses expected 0", bp);
    end
    press(5'b10011, 30, 30, pulses, first);
    n_checks++;
    if (pulses !== 1 || first !== 2 + DEB) begin
      n_fail++;
      $display("FAIL bounce_strobe: got %0d pulses at %0d expected 1 at %0d",
               pulses, first, 2 + DEB);
    end
    n_checks++;
    if (Count_out !== 3'd2) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d expected 2", Count_out);
    end
    check_frame("bounce", 7'b0110000, 7'b1111000, 7'h7f, 7'h7f);
  endtask

  task automatic test_overflow();
    int pulses, first;
    do_clear();
    for (int d = 1; d <= 5; d++) begin
      press({1'b1, 4'(d)}, 25, 25, pulses, first);
      n_checks++;
      if (pulses !== 1) begin
        n_fail++;
        $display("FAIL ovf_strobe%0d: got %0d expected 1", d, pulses);
      end
      if (d == 4) begin
        n_checks++;
        if (Full_out !== 1'b1 || Count_out !== 3'd4) begin
          n_fail++;
          $display("FAIL ovf_full: got %b %0d expected 1 4",
                   Full_out, Count_out);
        end
        check_frame("ovf4", 7'b0011001, 7'b0110000,
                    7'b0100100, 7'b1111001);
      end
    end
    n_checks++;
    if (Full_out !== 1'b1 || Count_out !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_hold: got %b %0d expected 1 4",
               Full_out, Count_out);
    end
    check_frame("ovf5", 7'b0011001, 7'b0110000,
                7'b0100100, 7'b1111001);
  endtask

  task automatic test_clear_accept();
    int pulses, first;
    do_clear();
    press(5'b10110, 25, 25, pulses, first);
    pulses = 0;
    first  = -1;
    Code_in = 5'b11001;
    for (int i = 0; i < 25; i++) begin
      Clear_in = (i == 2 + DEB);
      @(posedge Clk_in); #1;
      if (Key_strobe_out) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 1 + DEB) begin
        n_checks++;
        if (Count_out !== 3'd1) begin
          n_fail++;
          $display("FAIL clracc_pre: got %0d expected 1", Count_out);
        end
      end
    end
    Clear_in = 1'b0;
    Code_in = '0;
    repeat (25) @(posedge Clk_in);
    #1;
    n_checks++;
    if (pulses !== 1 || first !== 2 + DEB) begin
      n_fail++;
      $display("FAIL clracc_strobe: got %0d at %0d expected 1 at %0d",
               pulses, first, 2 + DEB);
    end
    n_checks++;
    if (Count_out !== 3'd0 || Full_out !== 1'b0) begin
      n_fail++;
      $display("FAIL clracc_count: got %0d %b expected 0 0",
               Count_out, Full_out);
    end
    check_frame("clracc", 7'h7f, 7'h7f, 7'h7f, 7'h7f);
  endtask

  task automatic test_scan_wrap();
    int pulses, first, waited;
    logic [3:0] prev, exp_a;
    logic [6:0] exp_s [4];
    do_clear();
    press(5'b10010, 25, 25, pulses, first);
    press(5'b10101, 25, 25, pulses, first);
    press(5'b11000, 25, 25, pulses, first);
    exp_s[0] = 7'b0000000;
    exp_s[1] = 7'b0010010;
    exp_s[2] = 7'b0100100;
    exp_s[3] = 7'b1111111;
    waited = 0;
    prev = Anode_out;
    @(posedge Clk_in); #1;
    while (!(Anode_out == 4'b1110 && prev != 4'b1110) && waited < 40) begin
      prev = Anode_out;
      @(posedge Clk_in); #1;
      waited++;
    end
    n_checks++;
    if (waited >= 40) begin
      n_fail++;
      $display("FAIL scan_sync: got timeout expected anode 1110 edge");
    end
    for (int k = 0; k <= 4 * SD; k++) begin
      exp_a = ~(4'b0001 << ((k / SD) % 4));
      n_checks++;
      if (Anode_out !== exp_a || Seg_out !== exp_s[(k / SD) % 4]) begin
        n_fail++;
        $display("FAIL scan_k%0d: got %b %b expected %b %b", k,
                 Anode_out, Seg_out, exp_a, exp_s[(k / SD) % 4]);
      end
      @(posedge Clk_in); #1;
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses, first;
    Code_in = 5'b10110;
    repeat (10) @(posedge Clk_in);
    #3;
    Rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({Seg_out, Anode_out, Count_out, Full_out, Key_strobe_out}
        !== {7'h7f, 4'hf, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_out: got %b %b %0d %b %b expected reset",
               Seg_out, Anode_out, Count_out, Full_out, Key_strobe_out);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge Clk_in); #1;
      if (Key_strobe_out) pulses++;
    end
    @(negedge Clk_in);
    Rst_n_in = 1'b1;
    first = -1;
    for (int i = 0; i < 25; i++) begin
      @(posedge Clk_in); #1;
      if (Key_strobe_out) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (pulses !== 1 || first !== 2 + DEB) begin
      n_fail++;
      $display("FAIL midrst_strobe: got %0d at %0d expected 1 at %0d",
               pulses, first, 2 + DEB);
    end
    n_checks++;
    if (Count_out !== 3'd1) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d expected 1", Count_out);
    end
    Code_in = '0;
    repeat (25) @(posedge Clk_in);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_overflow();
    test_clear_accept();
    test_scan_wrap();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
